// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read-path arbiter: FSM states, target
// select encodings, the decode-error response code and the region decoder.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DFLT = 2'd3
  } rd_state_e;

  localparam logic [1:0]  SSEL_S0     = 2'd0;
  localparam logic [1:0]  SSEL_S1     = 2'd1;
  localparam logic [1:0]  SSEL_DFLT   = 2'd2;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [31:0] REGION_MASK = 32'hFFFF_0000;

  // Map an address onto IM, DM or the default slave using the upper 16 bits.
  function automatic logic [1:0] decode_region(input logic [31:0] addr,
                                               input logic [31:0] s0_base,
                                               input logic [31:0] s1_base);
    logic [1:0] sel;
    if ((addr & REGION_MASK) == (s0_base & REGION_MASK)) begin
      sel = SSEL_S0;
    end else if ((addr & REGION_MASK) == (s1_base & REGION_MASK)) begin
      sel = SSEL_S1;
    end else begin
      sel = SSEL_DFLT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from the
// request vector and a one-bit priority pointer; the pointer only moves when
// the owner enables a grant, and then points at the loser.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_any,
  output logic       gnt_idx
);

  logic ptr_r;

  // Pick the winner: pointer master on contention, else the lone requester.
  always_comb begin
    gnt_any = |req;
    if (req == 2'b11) begin
      gnt_idx = ptr_r;
    end else begin
      gnt_idx = req[1];
    end
  end

  // Hand priority to the non-granted master whenever a grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (en && gnt_any) begin
      ptr_r <= ~gnt_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Read-path controller: arbitrates AR between the fetch (M0) and data (M1)
// masters, decodes the target region and steers R back to the owner until
// the last beat. One read is outstanding at a time; unmapped addresses are
// answered locally with a decode-error burst of ARLEN+1 beats.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int          IDW     = 4,
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [1:0][IDW-1:0] ARID_M,
  input  logic [1:0][31:0]    ARADDR_M,
  input  logic [1:0][3:0]     ARLEN_M,
  input  logic [1:0]          ARVALID_M,
  output logic [1:0]          ARREADY_M,
  output logic [IDW+3:0]      ARID_S,
  output logic [31:0]         ARADDR_S,
  output logic [3:0]          ARLEN_S,
  output logic [1:0]          ARVALID_S,
  input  logic [1:0]          ARREADY_S,
  input  logic [1:0]          RVALID_S,
  input  logic [1:0]          RLAST_S,
  output logic [1:0]          RREADY_S,
  output logic [1:0]          RVALID_M,
  output logic [1:0]          RLAST_M,
  input  logic [1:0]          RREADY_M,
  output logic                msel,
  output logic [1:0]          ssel,
  output logic                decerr
);

  rd_state_e      state_r;
  logic           msel_r;
  logic [1:0]     ssel_r;
  logic [IDW-1:0] arid_r;
  logic [31:0]    araddr_r;
  logic [3:0]     arlen_r;
  logic [3:0]     beat_cnt_r;
  logic           dflt_addr_r;

  logic           gnt_any_s;
  logic           gnt_idx_s;
  logic [1:0]     dec_s;
  logic           slv_s;

  rr_arb2 u_arb (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .req     (ARVALID_M),
    .en      (state_r == IDLE),
    .gnt_any (gnt_any_s),
    .gnt_idx (gnt_idx_s)
  );

  assign dec_s    = decode_region(ARADDR_M[gnt_idx_s], S0_BASE, S1_BASE);
  assign slv_s    = ssel_r[0];
  assign msel     = msel_r;
  assign ssel     = ssel_r;
  assign ARID_S   = {3'b000, msel_r, arid_r};
  assign ARADDR_S = araddr_r;
  assign ARLEN_S  = arlen_r;

  // Sequence grant, address, data and default-slave phases of one read.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r     <= IDLE;
      msel_r      <= 1'b0;
      ssel_r      <= SSEL_S0;
      arid_r      <= '0;
      araddr_r    <= 32'h0000_0000;
      arlen_r     <= 4'd0;
      beat_cnt_r  <= 4'd0;
      dflt_addr_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_any_s) begin
            msel_r      <= gnt_idx_s;
            arid_r      <= ARID_M[gnt_idx_s];
            araddr_r    <= ARADDR_M[gnt_idx_s];
            arlen_r     <= ARLEN_M[gnt_idx_s];
            ssel_r      <= dec_s;
            beat_cnt_r  <= 4'd0;
            dflt_addr_r <= (dec_s == SSEL_DFLT);
            state_r     <= (dec_s == SSEL_DFLT) ? DFLT : ADDR;
          end
        end
        ADDR: begin
          if (ARREADY_S[slv_s]) begin
            state_r <= DATA;
          end
        end
        DATA: begin
          if (RVALID_S[slv_s] && RREADY_M[msel_r] && RLAST_S[slv_s]) begin
            state_r <= IDLE;
          end
        end
        DFLT: begin
          if (dflt_addr_r) begin
            dflt_addr_r <= 1'b0;
          end else if (RREADY_M[msel_r]) begin
            if (beat_cnt_r == arlen_r) begin
              beat_cnt_r <= 4'd0;
              state_r    <= IDLE;
            end else begin
              beat_cnt_r <= beat_cnt_r + 4'd1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Drive handshake lanes for the owning master/slave pair; others stay 0.
  always_comb begin
    ARVALID_S = 2'b00;
    ARREADY_M = 2'b00;
    RREADY_S  = 2'b00;
    RVALID_M  = 2'b00;
    RLAST_M   = 2'b00;
    decerr    = 1'b0;
    case (state_r)
      ADDR: begin
        ARVALID_S[slv_s]  = 1'b1;
        ARREADY_M[msel_r] = ARREADY_S[slv_s];
      end
      DATA: begin
        RVALID_M[msel_r] = RVALID_S[slv_s];
        RLAST_M[msel_r]  = RLAST_S[slv_s];
        RREADY_S[slv_s]  = RREADY_M[msel_r];
      end
      DFLT: begin
        decerr = 1'b1;
        if (dflt_addr_r) begin
          ARREADY_M[msel_r] = 1'b1;
        end else begin
          RVALID_M[msel_r] = 1'b1;
          RLAST_M[msel_r]  = (beat_cnt_r == arlen_r);
        end
      end
      default: decerr = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0][3:0]  arid_m;
  logic [1:0][31:0] araddr_m;
  logic [1:0][3:0]  arlen_m;
  logic [1:0]       arvalid_m;
  logic [1:0]       arready_m;
  logic [7:0]       arid_s;
  logic [31:0]      araddr_s;
  logic [3:0]       arlen_s;
  logic [1:0]       arvalid_s;
  logic [1:0]       arready_s;
  logic [1:0]       rvalid_s;
  logic [1:0]       rlast_s;
  logic [1:0]       rready_s;
  logic [1:0]       rvalid_m;
  logic [1:0]       rlast_m;
  logic [1:0]       rready_m;
  logic             msel;
  logic [1:0]       ssel;
  logic             decerr;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.IDW(4)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .ARID_M(arid_m), .ARADDR_M(araddr_m), .ARLEN_M(arlen_m),
    .ARVALID_M(arvalid_m), .ARREADY_M(arready_m),
    .ARID_S(arid_s), .ARADDR_S(araddr_s), .ARLEN_S(arlen_s),
    .ARVALID_S(arvalid_s), .ARREADY_S(arready_s),
    .RVALID_S(rvalid_s), .RLAST_S(rlast_s), .RREADY_S(rready_s),
    .RVALID_M(rvalid_m), .RLAST_M(rlast_m), .RREADY_M(rready_m),
    .msel(msel), .ssel(ssel), .decerr(decerr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    arvalid_m = 2'b00;
    arready_s = 2'b00;
    rvalid_s  = 2'b00;
    rlast_s   = 2'b00;
    rready_m  = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    arid_m[m]    = id;
    araddr_m[m]  = addr;
    arlen_m[m]   = len;
    arvalid_m[m] = 1'b1;
  endtask

  initial begin
    arid_m   = '0;
    araddr_m = '0;
    arlen_m  = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check_eq("rst_msel", msel, 1'b0);
    check_eq("rst_ssel", ssel, 2'd0);
    check_eq("rst_decerr", decerr, 1'b0);
    check_eq("rst_arvalid_s", arvalid_s, 2'b00);
    check_eq("rst_rvalid_m", rvalid_m, 2'b00);

    // T1: M0 reads 0x40 len 3 from S0, ready immediately
    tick();
    set_req(0, 4'h5, 32'h0000_0040, 4'd3);
    arready_s = 2'b11;
    @(negedge clk);
    check_eq("t1_lat_arvalid_s", arvalid_s, 2'b00);
    tick();
    @(negedge clk);
    check_eq("t1_arvalid_s", arvalid_s, 2'b01);
    check_eq("t1_arready_m", arready_m, 2'b01);
    check_eq("t1_arid_s", arid_s, 8'h05);
    check_eq("t1_araddr_s", araddr_s, 32'h0000_0040);
    check_eq("t1_arlen_s", arlen_s, 4'd3);
    tick();
    arvalid_m = 2'b00;
    check_eq("t1_arready_m_once", arready_m, 2'b00);
    for (int i = 0; i < 4; i++) begin
      rvalid_s = 2'b01;
      rlast_s  = (i == 3) ? 2'b01 : 2'b00;
      @(negedge clk);
      check_eq("t1_rvalid_m", rvalid_m, 2'b01);
      check_eq("t1_rlast_m", rlast_m, (i == 3) ? 2'b01 : 2'b00);
      check_eq("t1_rready_s", rready_s, 2'b01);
      tick();
    end
    rvalid_s = 2'b00;
    rlast_s  = 2'b00;
    @(negedge clk);
    check_eq("t1_idle_rvalid_m", rvalid_m, 2'b00);
    check_eq("t1_idle_arvalid_s", arvalid_s, 2'b00);

    // T2: simultaneous requests after reset, round-robin order
    do_reset();
    set_req(0, 4'h1, 32'h0000_0100, 4'd0);
    set_req(1, 4'h2, 32'h0001_0200, 4'd0);
    arready_s = 2'b11;
    tick();
    @(negedge clk);
    check_eq("t2_first_msel", msel, 1'b0);
    check_eq("t2_first_arvalid_s", arvalid_s, 2'b01);
    tick();
    arvalid_m[0] = 1'b0;
    rvalid_s = 2'b01;
    rlast_s  = 2'b01;
    @(negedge clk);
    check_eq("t2_m0_rlast", rlast_m, 2'b01);
    tick();
    rvalid_s = 2'b00;
    rlast_s  = 2'b00;
    @(negedge clk);
    check_eq("t2_gap_arvalid_s", arvalid_s, 2'b00);
    tick();
    @(negedge clk);
    check_eq("t2_second_msel", msel, 1'b1);
    check_eq("t2_second_arvalid_s", arvalid_s, 2'b10);
    check_eq("t2_second_arid_s", arid_s, 8'h12);
    tick();
    arvalid_m[1] = 1'b0;
    rvalid_s = 2'b10;
    rlast_s  = 2'b10;
    @(negedge clk);
    check_eq("t2_m1_rvalid", rvalid_m, 2'b10);
    tick();
    rvalid_s = 2'b00;
    rlast_s  = 2'b00;
    set_req(0, 4'h3, 32'h0000_0200, 4'd0);
    set_req(1, 4'h4, 32'h0001_0300, 4'd0);
    tick();
    @(negedge clk);
    check_eq("t2_ptr_back_msel", msel, 1'b0);

    // T3: S1 stalls ARREADY for 5 cycles
    do_reset();
    set_req(1, 4'h3, 32'h0001_0008, 4'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_hold_arvalid_s", arvalid_s, 2'b10);
      check_eq("t3_hold_araddr_s", araddr_s, 32'h0001_0008);
      check_eq("t3_hold_arready_m", arready_m, 2'b00);
      tick();
    end
    arready_s = 2'b10;
    @(negedge clk);
    check_eq("t3_accept_arready_m", arready_m, 2'b10);
    check_eq("t3_ssel", ssel, 2'd1);
    tick();
    arvalid_m = 2'b00;
    arready_s = 2'b00;
    @(negedge clk);
    check_eq("t3_data_arvalid_s", arvalid_s, 2'b00);

    // T4: unmapped address, default slave with 3 beats
    do_reset();
    set_req(1, 4'h7, 32'h0002_0000, 4'd2);
    tick();
    @(negedge clk);
    check_eq("t4_arready_m", arready_m, 2'b10);
    check_eq("t4_ssel", ssel, 2'd2);
    check_eq("t4_decerr_addr", decerr, 1'b1);
    check_eq("t4_rvalid_addr", rvalid_m, 2'b00);
    tick();
    arvalid_m = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t4_rvalid_m", rvalid_m, 2'b10);
      check_eq("t4_rlast_m", rlast_m, (i == 2) ? 2'b10 : 2'b00);
      check_eq("t4_decerr", decerr, 1'b1);
      check_eq("t4_arvalid_s", arvalid_s, 2'b00);
      tick();
    end
    @(negedge clk);
    check_eq("t4_end_decerr", decerr, 1'b0);
    check_eq("t4_end_rvalid", rvalid_m, 2'b00);

    // T5: RREADY drop holds the default-slave beat counter
    do_reset();
    set_req(0, 4'h2, 32'h0005_0000, 4'd1);
    tick();
    tick();
    arvalid_m = 2'b00;
    @(negedge clk);
    check_eq("t5_beat0_rlast", rlast_m, 2'b00);
    tick();
    rready_m = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("t5_stall_rvalid", rvalid_m, 2'b01);
      check_eq("t5_stall_rlast", rlast_m, 2'b01);
      tick();
    end
    rready_m = 2'b01;
    @(negedge clk);
    check_eq("t5_last_rlast", rlast_m, 2'b01);
    tick();
    @(negedge clk);
    check_eq("t5_end_decerr", decerr, 1'b0);

    // T6: RREADY follow in DATA, then reset during beat 2
    do_reset();
    set_req(0, 4'h6, 32'h0000_0000, 4'd3);
    arready_s = 2'b01;
    tick();
    tick();
    arvalid_m = 2'b00;
    rvalid_s  = 2'b01;
    @(negedge clk);
    check_eq("t6_beat0_rready_s", rready_s, 2'b01);
    tick();
    rready_m = 2'b00;
    @(negedge clk);
    check_eq("t6_stall_rready_s", rready_s, 2'b00);
    check_eq("t6_stall_rvalid_m", rvalid_m, 2'b01);
    tick();
    rready_m = 2'b01;
    @(negedge clk);
    check_eq("t6_resume_rready_s", rready_s, 2'b01);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_rvalid_m", rvalid_m, 2'b00);
    check_eq("t6_rst_rready_s", rready_s, 2'b00);
    check_eq("t6_rst_araddr_s", araddr_s, 32'h0000_0000);
    check_eq("t6_rst_arid_s", arid_s, 8'h00);
    check_eq("t6_rst_arlen_s", arlen_s, 4'd0);
    check_eq("t6_rst_sel", {msel, ssel, decerr}, 4'b0000);
    rvalid_s = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_req(1, 4'h9, 32'h0001_0000, 4'd0);
    arready_s = 2'b00;
    @(negedge clk);
    check_eq("t6_post_idle", arvalid_s, 2'b00);
    tick();
    @(negedge clk);
    check_eq("t6_post_msel", msel, 1'b1);
    check_eq("t6_post_arvalid_s", arvalid_s, 2'b10);
    check_eq("t6_post_arid_s", arid_s, 8'h19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
